// File: rtl/i2s_audio_tx.sv
// I2S transmitter: latches a stereo sample pair once per frame, left-justifies it
// into OUT_WIDTH-bit slots and shifts it out MSB first on a divided bit clock.
module i2s_audio_tx #(
  parameter int unsigned IN_WIDTH    = 6,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned CLK_DIV     = 8,
  parameter bit          UNSIGNED_IN = 1'b1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                enable,
  input  logic                mute,
  input  logic [IN_WIDTH-1:0] left_in,
  input  logic [IN_WIDTH-1:0] right_in,
  output logic                sample_req,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(OUT_WIDTH);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(OUT_WIDTH - 1);
  localparam logic [IN_WIDTH-1:0] MSB_FLIP = IN_WIDTH'(UNSIGNED_IN) << (IN_WIDTH - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 chan;
  logic [OUT_WIDTH-1:0] left_sr;
  logic [OUT_WIDTH-1:0] right_sr;
  logic [OUT_WIDTH-1:0] left_fmt;
  logic [OUT_WIDTH-1:0] right_fmt;
  logic                 fall;

  // Offset-binary fix-up, then keep the top OUT_WIDTH bits of {sample, zeros}
  always_comb begin
    left_fmt  = OUT_WIDTH'({left_in  ^ MSB_FLIP, {OUT_WIDTH{1'b0}}} >> IN_WIDTH);
    right_fmt = OUT_WIDTH'({right_in ^ MSB_FLIP, {OUT_WIDTH{1'b0}}} >> IN_WIDTH);
    if (mute) begin
      left_fmt  = '0;
      right_fmt = '0;
    end
  end

  assign fall = i2s_bck && (div_cnt == DIV_LAST);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      chan       <= 1'b1;
      left_sr    <= '0;
      right_sr   <= '0;
      sample_req <= 1'b0;
      i2s_bck    <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_data   <= 1'b0;
    end else if (!enable) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      chan       <= 1'b1;
      left_sr    <= '0;
      right_sr   <= '0;
      sample_req <= 1'b0;
      i2s_bck    <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_data   <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        i2s_bck <= ~i2s_bck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      // Data and word select move on BCK falls so the receiver samples on rises
      if (fall) begin
        i2s_data <= chan ? right_sr[OUT_WIDTH-1] : left_sr[OUT_WIDTH-1];
        if (chan) right_sr <= right_sr << 1;
        else      left_sr  <= left_sr << 1;
        if (bit_cnt == BIT_LAST) begin
          bit_cnt  <= '0;
          chan     <= ~chan;
          i2s_lrck <= ~chan;
          if (chan) begin
            left_sr    <= left_fmt;
            right_sr   <= right_fmt;
            sample_req <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: an I2S receiver model collects slot words, which are
// compared against expected words queued by each scenario.
module tb_i2s_audio_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mute;
  logic [5:0]  l6, r6;
  logic [23:0] l24, r24;
  logic req0, bck0, lr0, d0;
  logic req1, bck1, lr1, d1;
  logic req2, bck2, lr2, d2;

  i2s_audio_tx u0 (
    .clk_sys(clk), .reset(rst), .enable(en), .mute(mute),
    .left_in(l6), .right_in(r6),
    .sample_req(req0), .i2s_bck(bck0), .i2s_lrck(lr0), .i2s_data(d0));

  i2s_audio_tx #(.IN_WIDTH(24), .OUT_WIDTH(16), .CLK_DIV(2), .UNSIGNED_IN(1'b0)) u1 (
    .clk_sys(clk), .reset(rst), .enable(en), .mute(mute),
    .left_in(l24), .right_in(r24),
    .sample_req(req1), .i2s_bck(bck1), .i2s_lrck(lr1), .i2s_data(d1));

  i2s_audio_tx #(.IN_WIDTH(6), .OUT_WIDTH(32), .CLK_DIV(2), .UNSIGNED_IN(1'b1)) u2 (
    .clk_sys(clk), .reset(rst), .enable(en), .mute(mute),
    .left_in(l6), .right_in(r6),
    .sample_req(req2), .i2s_bck(bck2), .i2s_lrck(lr2), .i2s_data(d2));

  int   sel = 0;
  int   nbits = 16;
  logic s_req, s_bck, s_lr, s_d;

  always_comb begin
    case (sel)
      1:       {s_req, s_bck, s_lr, s_d} = {req1, bck1, lr1, d1};
      2:       {s_req, s_bck, s_lr, s_d} = {req2, bck2, lr2, d2};
      default: {s_req, s_bck, s_lr, s_d} = {req0, bck0, lr0, d0};
    endcase
  end

  typedef struct {
    logic        ch;
    logic [31:0] word;
    int          len;
  } word_t;

  word_t got_q[$];
  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    clr_req = 0;

  // Receiver model: sample on BCK rises; an LRCK change marks the last bit of a slot
  int          clr_seen = 0;
  logic        prev_bck = 1'b0;
  logic        prev_lr = 1'b0;
  logic [31:0] acc = '0;
  int          run = 0;
  always @(negedge clk) begin
    logic [31:0] mask;
    word_t       w;
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      acc = '0;
      run = 0;
      prev_lr = 1'b0;
      got_q.delete();
    end
    if (s_bck && !prev_bck) begin
      acc = {acc[30:0], s_d};
      run++;
      if (s_lr != prev_lr) begin
        mask = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
        w.ch = prev_lr;
        w.word = acc & mask;
        w.len = run;
        got_q.push_back(w);
        acc = '0;
        run = 0;
      end
      prev_lr = s_lr;
    end
    prev_bck = s_bck;
  end

  task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
    word_t w;
    w.len = 0;
    w.ch = 1'b0; w.word = l; exp_q.push_back(w);
    w.ch = 1'b1; w.word = r; exp_q.push_back(w);
  endtask

  // Disable every instance, retarget the receiver, then enable from a clean state
  task automatic start(input int s, input int n);
    en = 1'b0;
    repeat (2) @(negedge clk);
    sel = s;
    nbits = n;
    clr_req++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic wait_words(input int n, output bit ok);
    for (int i = 0; i < 8000 && got_q.size() < n; i++) @(negedge clk);
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_req(output bit ok);
    for (int i = 0; i < 2000 && !s_req; i++) @(negedge clk);
    ok = s_req;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; mute = 1'b0;
    l6 = '0; r6 = '0; l24 = '0; r24 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req0, bck0, lr0, d0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {req0, bck0, lr0, d0});
    end
    en = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ({req0, bck0, lr0, d0, req1, bck1, req2, bck2} !== 8'b0) begin
      errors++;
      $display("FAIL reset_dominates got %b exp 00000000",
               {req0, bck0, lr0, d0, req1, bck1, req2, bck2});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    word_t g, e;
    l6 = 6'h3F; r6 = 6'h00;
    start(0, 16);
    push_frame(32'h7C00, 32'h8000);
    push_frame(32'h7C00, 32'h8000);
    wait_words(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got %0d words exp 4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.ch !== e.ch || g.word !== e.word) begin
        errors++;
        $display("FAIL basic_word%0d got ch%0d %h exp ch%0d %h", i, g.ch, g.word, e.ch, e.word);
      end
      if (i > 0) begin
        checks++;
        if (g.len != 16) begin errors++; $display("FAIL basic_len%0d got %0d exp 16", i, g.len); end
      end
    end
  endtask

  task automatic test_zero_and_period;
    bit ok;
    int cnt;
    word_t g, e;
    l6 = 6'h20; r6 = 6'h3F;
    start(0, 16);
    push_frame(32'h0000, 32'h7C00);
    wait_words(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout got %0d words exp 2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.ch !== e.ch || g.word !== e.word) begin
        errors++;
        $display("FAIL zero_word%0d got ch%0d %h exp ch%0d %h", i, g.ch, g.word, e.ch, e.word);
      end
    end
    wait_req(ok);
    @(negedge clk);
    checks++;
    if (!ok || s_req !== 1'b0) begin
      errors++;
      $display("FAIL req_width got seen=%0d after=%b exp seen=1 after=0", ok, s_req);
    end
    cnt = 1;
    while (!s_req && cnt < 2000) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt != 512) begin errors++; $display("FAIL req_period got %0d exp 512", cnt); end
  endtask

  task automatic test_mute;
    bit ok;
    word_t g, e;
    l6 = 6'h3F; r6 = 6'h00; mute = 1'b0;
    start(0, 16);
    push_frame(32'h7C00, 32'h8000);
    push_frame(32'h0000, 32'h0000);
    push_frame(32'h7C00, 32'h8000);
    wait_req(ok);
    repeat (100) @(negedge clk);
    mute = 1'b1;
    wait_req(ok);
    repeat (100) @(negedge clk);
    mute = 1'b0;
    wait_words(6, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mute_timeout got %0d words exp 6", got_q.size()); end
    for (int i = 0; i < 6 && got_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.ch !== e.ch || g.word !== e.word) begin
        errors++;
        $display("FAIL mute_word%0d got ch%0d %h exp ch%0d %h", i, g.ch, g.word, e.ch, e.word);
      end
    end
  endtask

  task automatic test_div2_truncate;
    bit ok;
    int cnt;
    word_t g, e;
    l24 = 24'h123456; r24 = 24'hABCDEF;
    start(1, 16);
    push_frame(32'h1234, 32'hABCD);
    push_frame(32'h1234, 32'hABCD);
    wait_words(4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div2_timeout got %0d words exp 4", got_q.size()); end
    for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.ch !== e.ch || g.word !== e.word || (i > 0 && g.len != 16)) begin
        errors++;
        $display("FAIL div2_word%0d got ch%0d %h len %0d exp ch%0d %h len 16",
                 i, g.ch, g.word, g.len, e.ch, e.word);
      end
    end
    for (int i = 0; i < 100 && s_bck; i++) @(negedge clk);
    for (int i = 0; i < 100 && !s_bck; i++) @(negedge clk);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (s_bck && cnt < 100);
    do begin @(negedge clk); cnt++; end while (!s_bck && cnt < 100);
    checks++;
    if (cnt != 4) begin errors++; $display("FAIL div2_bck_period got %0d exp 4", cnt); end
    wait_req(ok);
    @(negedge clk);
    cnt = 1;
    while (!s_req && cnt < 2000) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt != 128) begin errors++; $display("FAIL div2_req_period got %0d exp 128", cnt); end
  endtask

  task automatic test_wide_slot;
    bit ok;
    word_t g, e;
    l6 = 6'h3F; r6 = 6'h01;
    start(2, 32);
    push_frame(32'h7C00_0000, 32'h8400_0000);
    wait_words(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wide_timeout got %0d words exp 2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.ch !== e.ch || g.word !== e.word) begin
        errors++;
        $display("FAIL wide_word%0d got ch%0d %h exp ch%0d %h", i, g.ch, g.word, e.ch, e.word);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cnt;
    word_t g, e;
    l6 = 6'h3F; r6 = 6'h00;
    start(0, 16);
    wait_req(ok);
    repeat (8 * 16) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req0, bck0, lr0, d0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b exp 0000", {req0, bck0, lr0, d0});
    end
    clr_req++;
    exp_q.delete();
    push_frame(32'h7C00, 32'h8000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (!s_req && cnt < 200) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt != 16) begin errors++; $display("FAIL reset_first_req got %0d exp 16", cnt); end
    wait_words(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_timeout got %0d words exp 2", got_q.size()); end
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.ch !== e.ch || g.word !== e.word) begin
        errors++;
        $display("FAIL reset_word%0d got ch%0d %h exp ch%0d %h", i, g.ch, g.word, e.ch, e.word);
      end
    end
  endtask

  task automatic test_disable;
    int bad;
    int cnt;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if ({req0, bck0, lr0, d0, req1, bck1, lr1, d1, req2, bck2, lr2, d2} !== 12'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL disable_hold got %0d nonzero cycles exp 0", bad); end
    en = 1'b1;
    cnt = 0;
    while (!req0 && cnt < 200) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt != 16) begin errors++; $display("FAIL enable_first_req got %0d exp 16", cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_and_period();
    test_mute();
    test_div2_truncate();
    test_wide_slot();
    test_reset_mid();
    test_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
Parametrised I2S transmitter that replaces the fixed 6-bit-to-16-bit audio path of the MiST/Calypso top levels. It takes stereo core samples of any width and optionally converts unsigned samples to two's complement. It left-justifies each sample into a configurable slot width and generates BCK/LRCK/DATA from clk_sys with an integer divider. Samples are latched once per frame, and a latch strobe is returned to the core.

Parameters:
IN_WIDTH, 6, bits per input sample (1..24)
OUT_WIDTH, 16, bits per I2S channel slot (8..32)
CLK_DIV, 8, clk_sys cycles per BCK half-period (>=2)
UNSIGNED_IN, 1, 1 = inputs are offset binary (MSB inverted on latch); 0 = inputs are already two's complement

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  0 = link idle: outputs held low, counters held at their reset values
mute  in  1  1 = zero samples are latched instead of the inputs
left_in  in  IN_WIDTH  left sample
right_in  in  IN_WIDTH  right sample
sample_req  out  1  one-clk_sys pulse in the cycle the inputs are latched
i2s_bck  out  1  bit clock
i2s_lrck  out  1  word select; 0 = left, 1 = right
i2s_data  out  1  serial data, MSB first

Behaviour:
- Reset values: all outputs 0. Internal state: div_cnt=0, bck=0, bit_cnt=OUT_WIDTH-1, chan=right, both shift registers 0.
- Asserting reset mid-frame: immediate return to reset state; no partial bits are emitted afterwards.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1.
  - At CLK_DIV-1 it wraps to 0 and bck toggles.
  - BCK period = 2*CLK_DIV clk_sys cycles; the first toggle after reset is a rising edge.
- Fall event: the clk_sys cycle in which bck goes 1->0. i2s_data, i2s_lrck, bit_cnt, chan and sample_req update only on fall events, so the receiver samples on BCK rising edges.
- On each fall event:
  - i2s_data <= MSB of the current channel's shift register; that register shifts left, filling 0.
  - If bit_cnt==OUT_WIDTH-1 (LSB being emitted): bit_cnt<=0, chan toggles, i2s_lrck <= new chan. This gives the standard one-BCK delay between LRCK change and the next MSB.
  - Otherwise bit_cnt increments.
- Latch: on the fall event where chan goes right->left, both shift registers load the processed samples and sample_req=1 for that cycle only. The first fall event after reset or enable is such an edge: it emits data=0 and lrck stays 0.
- Processing order:
  1. If UNSIGNED_IN, invert the MSB.
  2. If OUT_WIDTH>=IN_WIDTH, form {sample, (OUT_WIDTH-IN_WIDTH) zeros}; otherwise keep the top OUT_WIDTH bits and drop the rest.
  3. mute=1 forces the result to all-zeros (two's-complement silence).
- mute and the inputs are sampled only at the latch edge; changing them mid-frame has no effect until the next frame.
- Frame = 2*OUT_WIDTH BCK periods = 4*OUT_WIDTH*CLK_DIV clk_sys cycles (512 with defaults).
- enable 1->0: on the next clk_sys edge all state returns to reset values and outputs go 0. enable 0->1 starts a fresh frame exactly as after reset.
- Simultaneous reset and enable: reset dominates.

Test Plan:
- Defaults, UNSIGNED_IN=1, left=6'h3F, right=6'h00 → first full frame: left slot shifts 0x7C00, right slot 0x8000, MSB first, each bit valid at the BCK rise.
- Defaults, left=6'h20 → left slot 0x0000. Continuous run → sample_req pulses exactly every 512 clk_sys cycles, one cycle wide.
- CLK_DIV=2 → bck period 4 cycles. lrck toggles on the fall event one BCK before each slot's MSB; 16 BCK periods per channel.
- mute=1 asserted mid-frame with left=6'h3F → current frame completes unchanged; the next frame is all zeros; mute=0 restores 0x7C00 the frame after.
- IN_WIDTH=24, OUT_WIDTH=16, UNSIGNED_IN=0, left=24'h123456 → slot 0x1234. IN_WIDTH=6, OUT_WIDTH=32, left=6'h3F → 0x7C000000.
- reset pulse at bit 7 of the left slot → all outputs 0 within one cycle. After release, the first fall event latches and sample_req pulses at 2*CLK_DIV cycles. enable=0 for 100 cycles holds all outputs 0.
